// File: rtl/rc4_pkg.sv
// Shared RC4 constants, the KSA state encoding and the key-byte select helper.
package rc4_pkg;

    localparam int S_WIDTH       = 8;
    localparam int S_DEPTH       = 256;
    localparam int KEY_BYTES_DEF = 3;
    localparam int KEY_BYTES_MAX = 32;

    typedef enum logic [3:0] {
        KSA_IDLE  = 4'd0,
        KSA_RD_I  = 4'd1,
        KSA_GET_I = 4'd2,
        KSA_RD_J  = 4'd3,
        KSA_GET_J = 4'd4,
        KSA_WR_I  = 4'd5,
        KSA_WR_J  = 4'd6,
        KSA_NEXT  = 4'd7,
        KSA_DONE  = 4'd8
    } ksa_state_e;

    // Byte 0 is the most significant byte of an nbytes-wide key held in the low bits.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES_MAX-1:0] key,
                                            input int unsigned                nbytes,
                                            input int unsigned                idx);
        if (idx >= nbytes) begin
            return 8'h00;
        end
        return 8'(key >> (8 * (nbytes - 1 - idx)));
    endfunction

endpackage

// File: rtl/ksa_swap.sv
// RC4 key-scheduling stage: permutes the 256-byte S memory in place using the secret key.
//   state | meaning
//   IDLE  | waiting for start, S-memory port released
//   RD_I  | present address i
//   GET_I | latch s[i], update j
//   RD_J  | present address j
//   GET_J | latch s[j]
//   WR_I  | write s[j] to i
//   WR_J  | write s[i] to j
//   NEXT  | advance i and key index, or finish
//   DONE  | one-cycle finish pulse
module ksa_swap
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [S_WIDTH-1:0]     address,
    output logic [S_WIDTH-1:0]     data,
    output logic                   wren,
    input  logic [S_WIDTH-1:0]     q,
    output logic                   selector,
    output logic                   finish
);

    localparam logic [7:0] KIDX_LAST = 8'(KEY_BYTES - 1);
    localparam logic [7:0] I_LAST    = 8'(S_DEPTH - 1);

    ksa_state_e state_q, state_d;

    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] kidx_q, kidx_d;

    logic [8*KEY_BYTES_MAX-1:0] key_ext;
    logic [7:0]                 key_cur;

    always_comb begin
        key_ext                  = '0;
        key_ext[8*KEY_BYTES-1:0] = secret_key;
    end

    assign key_cur = key_byte(key_ext, 32'(KEY_BYTES), {24'd0, kidx_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= KSA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = KSA_IDLE;
        case (state_q)
            KSA_IDLE:  state_d = start ? KSA_RD_I : KSA_IDLE;
            KSA_RD_I:  state_d = KSA_GET_I;
            KSA_GET_I: state_d = KSA_RD_J;
            KSA_RD_J:  state_d = KSA_GET_J;
            KSA_GET_J: state_d = KSA_WR_I;
            KSA_WR_I:  state_d = KSA_WR_J;
            KSA_WR_J:  state_d = KSA_NEXT;
            KSA_NEXT:  state_d = (i_q == I_LAST) ? KSA_DONE : KSA_RD_I;
            KSA_DONE:  state_d = KSA_IDLE;
            default:   state_d = KSA_IDLE;
        endcase
    end

    always_comb begin
        address  = '0;
        data     = '0;
        wren     = 1'b0;
        selector = (state_q != KSA_IDLE);
        finish   = (state_q == KSA_DONE);
        case (state_q)
            KSA_RD_I: address = i_q;
            KSA_RD_J: address = j_q;
            KSA_WR_I: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
            end
            KSA_WR_J: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
            end
            default: ;
        endcase
    end

    // q reflects the address presented in the previous cycle, so GET_x sees RD_x's read.
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        si_d   = si_q;
        sj_d   = sj_q;
        kidx_d = kidx_q;
        case (state_q)
            KSA_IDLE: begin
                if (start) begin
                    i_d    = '0;
                    j_d    = '0;
                    kidx_d = '0;
                end
            end
            KSA_GET_I: begin
                si_d = q;
                j_d  = j_q + q + key_cur;
            end
            KSA_GET_J: sj_d = q;
            KSA_NEXT: begin
                if (i_q != I_LAST) begin
                    i_d    = i_q + 8'd1;
                    kidx_d = (kidx_q == KIDX_LAST) ? 8'd0 : kidx_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q    <= '0;
            j_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            kidx_q <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
            kidx_q <= kidx_d;
        end
    end

endmodule

// File: tb/tb_ksa_swap.sv
// Self-checking bench for ksa_swap: registered-read S memory plus a software KSA reference.
module tb_ksa_swap;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [7:0]  q;
    logic        selector;
    logic        finish;

    always #5 clk = ~clk;

    ksa_swap #(.KEY_BYTES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .q          (q),
        .selector   (selector),
        .finish     (finish)
    );

    logic [7:0] mem [256];
    logic       init_mem;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_s [256];
    logic [15:0] exp_wr [$];
    logic [15:0] got_wr [$];
    bit          hold_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int kb(input logic [23:0] key, input int k);
        return int'((key >> (8 * (2 - k))) & 24'hFF);
    endfunction

    // Reference RC4 KSA over the first n indices, recording the two writes per index.
    task automatic model(input logic [23:0] key, input int n);
        int j;
        int t;
        j = 0;
        for (int i = 0; i < n; i++) begin
            j = (j + exp_s[i] + kb(key, i % 3)) % 256;
            exp_wr.push_back({8'(i), 8'(exp_s[j])});
            exp_wr.push_back({8'(j), 8'(exp_s[i])});
            t        = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        chk({tag, "_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int k = 0; k < n; k++) chk(tag, 32'(got_wr[k]), 32'(exp_wr[k]));
    endtask

    task automatic cmp_mem(input string tag);
        for (int a = 0; a < 256; a++) chk(tag, 32'(mem[a]), 32'(exp_s[a]));
    endtask

    function automatic logic [15:0] got_at(input int k);
        if (k < got_wr.size()) return got_wr[k];
        return 16'hxxxx;
    endfunction

    task automatic load_identity();
        @(negedge clk);
        init_mem = 1'b1;
        @(negedge clk);
        init_mem = 1'b0;
        for (int a = 0; a < 256; a++) exp_s[a] = a;
    endtask

    // Caller is at a negedge; start is sampled by the next posedge.
    task automatic launch(input logic [23:0] key);
        secret_key = key;
        start      = 1'b1;
        exp_wr.delete();
        got_wr.delete();
    endtask

    task automatic wait_done(input bit abuse, output int edges);
        edges = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (wren) got_wr.push_back({address, data});
            if (finish) begin
                if (!hold_start) start = 1'b0;
                return;
            end
            if (abuse) start = 1'($urandom_range(0, 1));
            else if (!hold_start) start = 1'b0;
        end
        chk("finish_timeout", 32'(edges), 32'd1793);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        logic [23:0] key;

        reset      = 1'b0;
        start      = 1'b0;
        secret_key = '0;
        hold_start = 1'b0;
        init_mem   = 1'b1;
        for (int a = 0; a < 256; a++) exp_s[a] = a;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        chk("in_reset", 32'({selector, wren, finish, address, data}), 32'd0);
        reset = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle", 32'({selector, wren, finish, address}), 32'd0);
        end

        // Zero key on identity S.
        launch(24'h000000);
        model(24'h000000, 256);
        wait_done(1'b0, edges);
        chk("zero_latency", 32'(edges - 1), 32'd1792);
        chk("zero_i0_wr_j", 32'(got_at(1)), 32'h0000);
        chk("zero_i1_wr_j", 32'(got_at(3)), 32'h0101);
        chk("zero_i2_wr_i", 32'(got_at(4)), 32'h0203);
        chk("zero_i2_wr_j", 32'(got_at(5)), 32'h0302);
        cmp_writes("zero_wr");
        @(negedge clk);
        chk("zero_finish_once", 32'({finish, selector}), 32'd0);
        cmp_mem("zero_mem");

        // Lab key on identity S, start toggled randomly while busy.
        load_identity();
        launch(24'h000249);
        model(24'h000249, 256);
        wait_done(1'b1, edges);
        chk("lab_latency", 32'(edges - 1), 32'd1792);
        chk("lab_nwrites", 32'(got_wr.size()), 32'd512);
        chk("lab_i1_wr_j", 32'(got_at(3)), 32'h0301);
        chk("lab_i2_key49", 32'(got_at(5)), 32'h4e02);
        chk("lab_i3_kwrap", 32'(got_at(7)), 32'h4f01);
        cmp_writes("lab_wr");
        @(negedge clk);
        chk("lab_finish_once", 32'({finish, selector}), 32'd0);
        cmp_mem("lab_mem");

        // Reset at i=100, then restart on the partially permuted memory.
        key = 24'($urandom);
        launch(key);
        model(key, 100);
        for (int e = 0; e < 701; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (wren) got_wr.push_back({address, data});
            start = 1'b0;
        end
        chk("i100_addr", 32'({selector, wren, address}), 32'({1'b1, 1'b0, 8'd100}));
        cmp_writes("partial_wr");
        #2 reset = 1'b0;
        #1 chk("rst_async", 32'({selector, wren, finish, address, data}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_idle", 32'({selector, wren, finish, address}), 32'd0);
        cmp_mem("partial_mem");

        key = 24'($urandom);
        launch(key);
        model(key, 256);
        wait_done(1'b0, edges);
        chk("restart_latency", 32'(edges - 1), 32'd1792);
        cmp_writes("restart_wr");
        @(negedge clk);
        cmp_mem("restart_mem");

        // start held through DONE: a second run begins right after finish.
        key        = 24'($urandom);
        hold_start = 1'b1;
        launch(key);
        model(key, 256);
        wait_done(1'b0, edges);
        chk("hold1_latency", 32'(edges - 1), 32'd1792);
        cmp_writes("hold1_wr");
        @(negedge clk);
        chk("hold_idle_gap", 32'({finish, selector, address}), 32'd0);
        cmp_mem("hold1_mem");
        hold_start = 1'b0;
        exp_wr.delete();
        got_wr.delete();
        model(key, 256);
        wait_done(1'b0, edges);
        chk("hold2_latency", 32'(edges - 1), 32'd1792);
        cmp_writes("hold2_wr");
        @(negedge clk);
        chk("hold2_end_idle", 32'({finish, selector}), 32'd0);
        cmp_mem("hold2_mem");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
